// File: rtl/mem_except.sv
// MEM-stage exception resolver: registers the EX exception flags, merges them with
// qualified interrupts (using WB-bypassed CP0 values) and raises flush/redirect.
module mem_except #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
  parameter bit          PENDING_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_excepttype_i,
  input  logic [31:0] ex_inst_addr_i,
  input  logic        ex_is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_address_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] cp0_epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [4:0]  ADDR_STATUS = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
  localparam logic [4:0]  ADDR_EPC    = 5'd14;
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  localparam logic [31:0] CODE_NONE     = 32'h0;
  localparam logic [31:0] CODE_INT      = 32'h1;
  localparam logic [31:0] CODE_SYSCALL  = 32'h8;
  localparam logic [31:0] CODE_INVALID  = 32'ha;
  localparam logic [31:0] CODE_TRAP     = 32'hd;
  localparam logic [31:0] CODE_OVERFLOW = 32'hc;
  localparam logic [31:0] CODE_ERET     = 32'he;

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state, state_next;
  logic        mem_valid;
  logic [4:0]  mem_flags;   // {eret, overflow, trap, invalid, syscall}
  logic [31:0] mem_addr;
  logic        mem_dslot;

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_req, int_active, report;
  logic [31:0] code;

  // Flush takes priority over stall so a reported instruction never repeats.
  always_ff @(posedge clk) begin
    if (rst || flush_o) begin
      mem_valid <= 1'b0;
      mem_flags <= 5'b0;
      mem_addr  <= 32'h0;
      mem_dslot <= 1'b0;
    end else if (!stall_i) begin
      mem_valid <= ex_valid_i;
      mem_flags <= ex_valid_i ? ex_excepttype_i[12:8] : 5'b0;
      mem_addr  <= ex_inst_addr_i;
      mem_dslot <= ex_is_in_delayslot_i;
    end
  end

  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        ADDR_STATUS: status_eff = wb_cp0_wdata_i;
        ADDR_CAUSE:  cause_eff  = (cp0_cause_i & ~CAUSE_WMASK) | (wb_cp0_wdata_i & CAUSE_WMASK);
        ADDR_EPC:    epc_eff    = wb_cp0_wdata_i;
        default: ;
      endcase
    end
  end

  assign int_req    = ((status_eff[15:8] & cause_eff[15:8]) != 8'h0) &&
                      !status_eff[1] && status_eff[0];
  assign report     = mem_valid && !stall_i && !rst;
  assign int_active = int_req || (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (PENDING_EN && int_req && !mem_valid) state_next = PEND;
      PEND: if (report || !int_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    code = CODE_NONE;
    if (report) begin
      if (int_active)        code = CODE_INT;
      else if (mem_flags[0]) code = CODE_SYSCALL;
      else if (mem_flags[1]) code = CODE_INVALID;
      else if (mem_flags[2]) code = CODE_TRAP;
      else if (mem_flags[3]) code = CODE_OVERFLOW;
      else if (mem_flags[4]) code = CODE_ERET;
    end
  end

  always_comb begin
    excepttype_o = code;
    flush_o      = (code != CODE_NONE);
    new_pc_o     = 32'h0;
    if (flush_o) new_pc_o = (code == CODE_ERET) ? epc_eff : HANDLER_ADDR;
  end

  assign current_inst_address_o = mem_addr;
  assign is_in_delayslot_o      = mem_dslot;
  assign cp0_epc_o              = epc_eff;

  logic unused_bits;
  assign unused_bits = ^{ex_excepttype_i[31:13], ex_excepttype_i[7:0],
                         status_eff[31:16], status_eff[7:2],
                         cause_eff[31:16], cause_eff[7:0]};

endmodule

// File: tb/tb_mem_except.sv
// Directed bench for mem_except: hand-computed exception codes, flush/redirect,
// CP0 bypass, stall/pending-interrupt behaviour and reset.
module tb_mem_except;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        ex_valid_i;
  logic [31:0] ex_excepttype_i;
  logic [31:0] ex_inst_addr_i;
  logic        ex_is_in_delayslot_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [31:0] excepttype_o, current_inst_address_o, cp0_epc_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  mem_except dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
    .ex_excepttype_i(ex_excepttype_i), .ex_inst_addr_i(ex_inst_addr_i),
    .ex_is_in_delayslot_i(ex_is_in_delayslot_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .excepttype_o(excepttype_o), .current_inst_address_o(current_inst_address_o),
    .is_in_delayslot_o(is_in_delayslot_o), .cp0_epc_o(cp0_epc_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] flags,
                               input logic [31:0] addr, input logic dslot);
    ex_valid_i           = valid;
    ex_excepttype_i      = flags;
    ex_inst_addr_i       = addr;
    ex_is_in_delayslot_i = dslot;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setWb(input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    wb_cp0_we_i    = we;
    wb_cp0_waddr_i = waddr;
    wb_cp0_wdata_i = wdata;
  endtask

  // Loads one instruction, checks its report, then checks the flush cleared MEM.
  task automatic issueAndCheck(input string tag, input logic [31:0] flags,
                               input logic [31:0] addr, input logic [31:0] expCode,
                               input logic [31:0] expPc);
    applyStimulus(1'b1, flags, addr, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput({tag, "_code"}, excepttype_o, expCode);
    checkOutput({tag, "_flush"}, {31'b0, flush_o}, {31'b0, expCode != 32'h0});
    checkOutput({tag, "_newpc"}, new_pc_o, expPc);
    checkOutput({tag, "_addr"}, current_inst_address_o, addr);
    step();
    #1;
    checkOutput({tag, "_after_code"}, excepttype_o, 32'h0);
    checkOutput({tag, "_after_flush"}, {31'b0, flush_o}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    cp0_status_i = 32'h0;
    cp0_cause_i  = 32'h0;
    cp0_epc_i    = 32'h0;
    setWb(1'b0, 5'd0, 32'h0);
    step();
    step();
    checkOutput("rst_code", excepttype_o, 32'h0);
    checkOutput("rst_flush", {31'b0, flush_o}, 32'h0);
    checkOutput("rst_newpc", new_pc_o, 32'h0);
    checkOutput("rst_addr", current_inst_address_o, 32'h0);
    checkOutput("rst_dslot", {31'b0, is_in_delayslot_o}, 32'h0);
    checkOutput("rst_epc", cp0_epc_o, 32'h0);
    rst = 1'b0;

    // Syscall reports for one cycle, then everything returns to 0.
    issueAndCheck("syscall", 32'h0000_0100, 32'h0000_0100, 32'h8, 32'h20);
    checkOutput("syscall_after_newpc", new_pc_o, 32'h0);
    checkOutput("syscall_after_addr", current_inst_address_o, 32'h0);

    // Priority among instruction flags.
    issueAndCheck("prio_sys_inv", 32'h0000_0300, 32'h0000_0110, 32'h8, 32'h20);
    issueAndCheck("prio_inv_trap", 32'h0000_0600, 32'h0000_0114, 32'ha, 32'h20);
    issueAndCheck("prio_trap_ovf", 32'h0000_0C00, 32'h0000_0118, 32'hd, 32'h20);
    issueAndCheck("prio_ovf_eret", 32'h0000_1800, 32'h0000_011C, 32'hc, 32'h20);
    issueAndCheck("no_flags", 32'hFFFF_E0FF, 32'h0000_0120, 32'h0, 32'h0);

    // Eret with EPC bypass from WB in the same cycle.
    cp0_epc_i = 32'h40;
    applyStimulus(1'b1, 32'h0000_1000, 32'h0000_0124, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    setWb(1'b1, 5'd14, 32'h80);
    #1;
    checkOutput("eret_code", excepttype_o, 32'he);
    checkOutput("eret_newpc", new_pc_o, 32'h80);
    checkOutput("eret_epc_bypass", cp0_epc_o, 32'h80);
    setWb(1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("eret_epc_reg", cp0_epc_o, 32'h40);
    step();
    issueAndCheck("eret_nobypass", 32'h0000_1000, 32'h0000_0128, 32'he, 32'h40);

    // Interrupt outranks overflow.
    cp0_status_i = 32'h0000_FF01;
    cp0_cause_i  = 32'h0000_0400;
    issueAndCheck("int_vs_ovf", 32'h0000_0800, 32'h0000_0130, 32'h1, 32'h20);
    cp0_status_i = 32'h0;
    cp0_cause_i  = 32'h0;
    step();

    // Pending interrupt across bubbles survives int_req dropping on arrival.
    cp0_status_i = 32'h0000_FF01;
    cp0_cause_i  = 32'h0000_0400;
    step();
    checkOutput("pend_bubble1", excepttype_o, 32'h0);
    step();
    checkOutput("pend_bubble2", {31'b0, flush_o}, 32'h0);
    applyStimulus(1'b1, 32'h0, 32'h0000_0200, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    cp0_cause_i = 32'h0;
    #1;
    checkOutput("pend_code", excepttype_o, 32'h1);
    checkOutput("pend_addr", current_inst_address_o, 32'h200);
    checkOutput("pend_dslot", {31'b0, is_in_delayslot_o}, 32'h1);
    checkOutput("pend_flush", {31'b0, flush_o}, 32'h1);
    step();
    checkOutput("pend_once", excepttype_o, 32'h0);
    cp0_status_i = 32'h0;
    step();

    // Syscall held by stall reports on the first unstalled cycle.
    applyStimulus(1'b1, 32'h0000_0100, 32'h0000_0300, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall%0d_code", i), excepttype_o, 32'h0);
      checkOutput($sformatf("stall%0d_flush", i), {31'b0, flush_o}, 32'h0);
      checkOutput($sformatf("stall%0d_addr", i), current_inst_address_o, 32'h300);
      step();
    end
    stall_i = 1'b0;
    #1;
    checkOutput("unstall_code", excepttype_o, 32'h8);
    checkOutput("unstall_flush", {31'b0, flush_o}, 32'h1);
    step();
    checkOutput("unstall_after", excepttype_o, 32'h0);

    // WB sets EXL: interrupt masked and no pending state is recorded.
    cp0_status_i = 32'h0000_FF01;
    cp0_cause_i  = 32'h0000_0400;
    setWb(1'b1, 5'd12, 32'h0000_FF03);
    applyStimulus(1'b1, 32'h0, 32'h0000_0400, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("mask_code", excepttype_o, 32'h0);
    checkOutput("mask_flush", {31'b0, flush_o}, 32'h0);
    step();
    step();
    setWb(1'b0, 5'd0, 32'h0);
    cp0_cause_i = 32'h0;
    applyStimulus(1'b1, 32'h0, 32'h0000_0404, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("mask_idle_code", excepttype_o, 32'h0);
    step();

    // Cause bypass only writes bits [9:8], [22], [23].
    applyStimulus(1'b1, 32'h0, 32'h0000_0500, 1'b0);
    step();
    applyStimulus(1'b1, 32'h0, 32'h0000_0504, 1'b0);
    setWb(1'b1, 5'd13, 32'h0000_0400);
    #1;
    checkOutput("cause_ro_bit", excepttype_o, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    setWb(1'b1, 5'd13, 32'h0000_0100);
    #1;
    checkOutput("cause_sw_int", excepttype_o, 32'h1);
    checkOutput("cause_sw_addr", current_inst_address_o, 32'h504);
    setWb(1'b0, 5'd0, 32'h0);
    cp0_status_i = 32'h0;
    step();

    // Reset during a stall drops the held instruction.
    applyStimulus(1'b1, 32'h0000_0100, 32'h0000_0600, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    stall_i = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall_i = 1'b0;
    #1;
    checkOutput("rst_stall_code", excepttype_o, 32'h0);
    checkOutput("rst_stall_addr", current_inst_address_o, 32'h0);
    checkOutput("rst_stall_dslot", {31'b0, is_in_delayslot_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_except.md
Name: mem_except

Overview:
- MEM-stage exception resolver. It sits between the EX/MEM boundary and the CP0 register block.
- Holds the MEM-stage exception pipeline register and merges pending hardware interrupts with instruction exceptions.
- Uses CP0 Status/Cause/EPC values bypassed from the WB-stage CP0 write.
- Drives the CP0 exception inputs (excepttype, current instruction address, delay-slot flag), the pipeline-wide flush and the redirect PC.

Parameters:
HANDLER_ADDR, 32'h00000020, exception vector loaded into new_pc_o
PENDING_EN, 1, 1 = hold a qualified interrupt across MEM bubbles until a valid instruction reaches MEM

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall_i  in  1  MEM hold request from the stall controller
ex_valid_i  in  1  EX slot holds a real instruction
ex_excepttype_i  in  32  flag bits: [8] syscall, [9] invalid instruction, [10] trap, [11] overflow, [12] eret; other bits ignored
ex_inst_addr_i  in  32  PC of the EX instruction
ex_is_in_delayslot_i  in  1  EX instruction sits in a branch delay slot
cp0_status_i  in  32  CP0 Status, registered value
cp0_cause_i  in  32  CP0 Cause, registered value
cp0_epc_i  in  32  CP0 EPC, registered value
wb_cp0_we_i  in  1  WB-stage CP0 write enable
wb_cp0_waddr_i  in  5  WB CP0 write address (12 status, 13 cause, 14 epc)
wb_cp0_wdata_i  in  32  WB CP0 write data
excepttype_o  out  32  code to CP0: 0x1 int, 0x8 syscall, 0xa invalid, 0xd trap, 0xc overflow, 0xe eret, 0 none
current_inst_address_o  out  32  PC of the MEM instruction
is_in_delayslot_o  out  1  delay-slot flag of the MEM instruction
cp0_epc_o  out  32  bypassed EPC
flush_o  out  1  flush all stages this cycle
new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- MEM register (valid, flags, addr, dslot):
  - rst: all fields cleared.
  - flush_o=1: register cleared; flush overrides stall.
  - stall_i=1: register holds.
  - Otherwise: loads the EX inputs; ex_valid_i=0 loads a bubble (valid=0, flags=0).
- Effective CP0 values (combinational bypass; a WB write wins over the registered value):
  - Status: full 32-bit replacement on a WB write to address 12.
  - Cause: WB write to address 13 replaces only bits [9:8], [22] and [23]; all other bits come from cp0_cause_i.
  - EPC: full replacement on a WB write to address 14; cp0_epc_o equals the effective EPC.
- Interrupt qualification: int_req = (status_eff[15:8] & cause_eff[15:8]) != 0 && status_eff[1]==0 && status_eff[0]==1.
- Pending FSM, states IDLE and PEND:
  - IDLE -> PEND: int_req=1 while the MEM register is not valid and PENDING_EN=1.
  - PEND -> IDLE: the interrupt is reported, or int_req drops, or rst.
  - A PEND interrupt is reported when the next valid MEM instruction is present and stall_i=0.
- Report condition: valid=1 and stall_i=0. No output code is ever produced while stalled or on a bubble.
- Code priority, highest first: interrupt (int_req or PEND) -> 0x1; syscall -> 0x8; invalid -> 0xa; trap -> 0xd; overflow -> 0xc; eret -> 0xe.
- When a code is reported in a cycle:
  - flush_o=1 in that same cycle.
  - new_pc_o = cp0_epc_o for eret, HANDLER_ADDR for every other code.
- Outputs with no code reported:
  - excepttype_o = 0, flush_o = 0, new_pc_o = 0.
  - current_inst_address_o and is_in_delayslot_o always follow the MEM register (0 when it is cleared).
- Each MEM instruction reports at most once, because the flush clears the register on the same edge.
- Reset values: all outputs 0, FSM = IDLE.
- rst mid-stall or while in PEND: everything is cleared and the pending interrupt is dropped.

Test Plan:
- Syscall: valid instruction at 0x00000100 with flag [8] set, stall_i=0 -> excepttype_o=0x8, flush_o=1, new_pc_o=0x20, current_inst_address_o=0x100 for exactly 1 cycle; the next cycle shows all outputs 0.
- Eret with bypass: cp0_epc_i=0x40; WB writes epc=0x80 in the same cycle as an eret in MEM -> excepttype_o=0xe, new_pc_o=0x80.
- Interrupt vs overflow: status=0x0000FF01, cause[10]=1, MEM holds an overflow instruction -> excepttype_o=0x1, not 0xc.
- Pending interrupt: int_req rises during 2 bubbles, then a valid instruction at 0x200 with delay-slot=1 arrives -> a single report with code 0x1, address 0x200, is_in_delayslot_o=1.
- Stall: syscall held in MEM for 3 stall cycles -> outputs 0 throughout the stall; code 0x8 is reported on the first unstalled cycle.
- Masking: WB writes status with EXL=1 while a cause IP bit is set -> no interrupt reported, FSM stays IDLE.
